// File: rtl/inv_mix_columns_unit.sv
// Iterative AES InvMixColumns stage with a MixEn/MixRy level handshake.
// Transforms COLS_PER_CYCLE columns of the captured state per clock.
module inv_mix_columns_unit #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         MixEn,
  input  logic [127:0] Text,
  output logic         MixRy,
  output logic [127:0] ModifiedText,
  output logic         Busy
);

  localparam logic [1:0] STEP       = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_START = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_d;
  logic [127:0] work, work_d;
  logic [1:0]   cnt, cnt_d;
  logic         mix_ry_d, busy_d;
  logic [127:0] mod_text_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the inverse matrix, products built from x2/x4/x8 chains.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = c[31-8*r -: 8];
      x2[r] = xt(a[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] mix_step(input logic [127:0] w, input logic [1:0] start);
    logic [127:0] r;
    r = w;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(start) && c < int'(start) + int'(COLS_PER_CYCLE))
        r[127-32*c -: 32] = inv_col(w[127-32*c -: 32]);
    end
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state        <= IDLE;
      work         <= '0;
      cnt          <= '0;
      MixRy        <= 1'b0;
      ModifiedText <= '0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_d;
      work         <= work_d;
      cnt          <= cnt_d;
      MixRy        <= mix_ry_d;
      ModifiedText <= mod_text_d;
      Busy         <= busy_d;
    end
  end

  always_comb begin
    state_d    = state;
    work_d     = work;
    cnt_d      = cnt;
    mix_ry_d   = MixRy;
    mod_text_d = ModifiedText;
    busy_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (MixEn) begin
          work_d  = Text;
          cnt_d   = '0;
          state_d = CALC;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        // Dropping MixEn mid-computation discards the partial result.
        if (!MixEn) begin
          state_d = IDLE;
        end else begin
          work_d = mix_step(work, cnt);
          cnt_d  = cnt + STEP;
          if (cnt == LAST_START) begin
            mod_text_d = work_d;
            mix_ry_d   = 1'b1;
            state_d    = DONE;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!MixEn) begin
          mix_ry_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inv_mix_columns_unit.sv
// Self-checking bench for inv_mix_columns_unit in 1-, 2- and 4-column builds.
module tb_inv_mix_columns_unit;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [127:0] text;
  logic         mix_en   [3];
  logic         mix_ry   [3];
  logic [127:0] mod_text [3];
  logic         busy     [3];
  int           cols     [3] = '{1, 2, 4};

  always #5 Clk = ~Clk;

  inv_mix_columns_unit #(.COLS_PER_CYCLE(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .MixEn(mix_en[0]), .Text(text),
    .MixRy(mix_ry[0]), .ModifiedText(mod_text[0]), .Busy(busy[0]));
  inv_mix_columns_unit #(.COLS_PER_CYCLE(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .MixEn(mix_en[1]), .Text(text),
    .MixRy(mix_ry[1]), .ModifiedText(mod_text[1]), .Busy(busy[1]));
  inv_mix_columns_unit #(.COLS_PER_CYCLE(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .MixEn(mix_en[2]), .Text(text),
    .MixRy(mix_ry[2]), .ModifiedText(mod_text[2]), .Busy(busy[2]));

  typedef struct {
    logic [127:0] in;
    logic [127:0] exp;
  } vec_t;

  int           compared   = 0;
  int           mismatched = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_result;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: generic shift-and-add GF(2^8) multiply reduced by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] coef(input int k);
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] model(input logic [127:0] t);
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef((k - row + 4) % 4), t[127-32*c-8*k -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    return r;
  endfunction

  // Raise MixEn with a vector, wait for MixRy, check latency, Busy span and result.
  task automatic run_op(input int d, input logic [127:0] t, input logic [127:0] exp,
                        input bit scramble, input string name);
    int           cyc;
    int           nbusy;
    logic [127:0] e;
    @(negedge Clk);
    text      = t;
    mix_en[d] = 1'b1;
    exp_q.push_back(exp);
    cyc   = 0;
    nbusy = 0;
    while (cyc < 20 && !mix_ry[d]) begin
      @(negedge Clk);
      cyc++;
      if (scramble) text = '1;
      if (busy[d]) nbusy++;
    end
    e = exp_q.pop_front();
    if (!mix_ry[d]) begin
      check({name, "_timeout"}, 128'(mix_ry[d]), 128'd1);
    end else begin
      check({name, "_latency"}, 128'(cyc - 1), 128'(4 / cols[d]));
      check({name, "_busy_cycles"}, 128'(nbusy), 128'(4 / cols[d]));
      check(name, mod_text[d], e);
      last_result = e;
    end
  endtask

  task automatic release_en(input int d, input string name);
    mix_en[d] = 1'b0;
    @(negedge Clk);
    check({name, "_ry_low"}, 128'(mix_ry[d]), 128'd0);
  endtask

  vec_t vecs [5];

  initial begin
    logic         stable;
    logic         ry_seen;
    logic [127:0] r;

    vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'hdb135345_f20a225c_01010101_d4d4d4d5};
    vecs[1] = '{128'hc6c6c6c6_c6c6c6c6_01010101_c6c6c6c6, 128'hc6c6c6c6_c6c6c6c6_01010101_c6c6c6c6};
    vecs[2] = '{128'h4d7ebdf8_8e4da1bc_d5d5d7d6_9fdc589d, 128'h2d26314c_db135345_d4d4d4d5_f20a225c};
    vecs[3] = '{128'h0, 128'h0};
    vecs[4] = '{{128{1'b1}}, {128{1'b1}}};

    Rst  = 1'b0;
    text = '0;
    for (int d = 0; d < 3; d++) mix_en[d] = 1'b0;
    last_result = '0;
    @(negedge Clk);
    @(negedge Clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ry_%0d", d), 128'(mix_ry[d]), 128'd0);
      check($sformatf("reset_busy_%0d", d), 128'(busy[d]), 128'd0);
      check($sformatf("reset_text_%0d", d), mod_text[d], 128'd0);
    end
    Rst = 1'b1;

    // Known vector, then hold MixEn high: no retrigger, outputs stable.
    run_op(0, vecs[0].in, vecs[0].exp, 1'b0, "vec0");
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (mix_ry[0] !== 1'b1 || busy[0] !== 1'b0 || mod_text[0] !== vecs[0].exp) stable = 1'b0;
    end
    check("hold_stable", 128'(stable), 128'd1);
    release_en(0, "vec0");

    for (int i = 1; i < 5; i++) begin
      run_op(0, vecs[i].in, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
      release_en(0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_op(0, r, model(r), 1'b0, $sformatf("rand%0d", i));
      release_en(0, $sformatf("rand%0d", i));
    end

    // Abort after two edges with MixEn high.
    @(negedge Clk);
    text      = vecs[2].in;
    mix_en[0] = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    mix_en[0] = 1'b0;
    @(negedge Clk);
    check("abort_busy", 128'(busy[0]), 128'd0);
    check("abort_keep", mod_text[0], last_result);
    ry_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (mix_ry[0] !== 1'b0) ry_seen = 1'b1;
    end
    check("abort_no_ry", 128'(ry_seen), 128'd0);

    // Text forced to all-ones after capture must not disturb the result.
    run_op(0, vecs[0].in, vecs[0].exp, 1'b1, "scramble");
    release_en(0, "scramble");

    // Synchronous reset on the third CALC edge.
    @(negedge Clk);
    text      = vecs[2].in;
    mix_en[0] = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("rst_mid_ry", 128'(mix_ry[0]), 128'd0);
    check("rst_mid_busy", 128'(busy[0]), 128'd0);
    check("rst_mid_text", mod_text[0], 128'd0);
    Rst       = 1'b1;
    mix_en[0] = 1'b0;
    @(negedge Clk);
    run_op(0, vecs[2].in, vecs[2].exp, 1'b0, "after_rst");
    release_en(0, "after_rst");

    // Wider builds: same vector, shorter latency.
    run_op(2, vecs[0].in, vecs[0].exp, 1'b0, "cols4");
    release_en(2, "cols4");
    run_op(1, vecs[0].in, vecs[0].exp, 1'b0, "cols2");
    release_en(1, "cols2");
    run_op(1, vecs[2].in, vecs[2].exp, 1'b0, "cols2_b");
    release_en(1, "cols2_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
